// File: rtl/sram_like_arbiter.sv
// Purpose: shares one SRAM-like memory port between the instruction and data channels, routing responses back in order.
// Latency: requests pass through combinationally (zero-cycle issue); responses are steered to their channel the same cycle.
// Backpressure: a grant is held until mem_addr_ok; issue stalls while OUTSTANDING transactions are unanswered.
module sram_like_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        resp_err
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [PW:0]            cnt_q;
    logic [OUTSTANDING-1:0] id_q;
    logic                   resp_err_q;

    logic owner_data;
    logic owner_req;
    logic full;
    logic issue;
    logic accept;
    logic pop;
    logic head_data;

    // Select which channel drives the memory port: free choice in IDLE (data wins as the older
    // instruction), locked to the granted channel while holding.
    always_comb begin
        owner_data = 1'b0;
        owner_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                owner_data = data_sram_req;
                owner_req  = data_sram_req | inst_sram_req;
            end
            ST_HOLD_I: begin
                owner_data = 1'b0;
                owner_req  = inst_sram_req;
            end
            ST_HOLD_D: begin
                owner_data = 1'b1;
                owner_req  = data_sram_req;
            end
            default: begin
                owner_data = 1'b0;
                owner_req  = 1'b0;
            end
        endcase
    end

    // Issue and response qualifiers; a pop in the full cycle deliberately does not unblock issue.
    always_comb begin
        full      = (cnt_q == FULL_CNT);
        issue     = !reset && !full && owner_req;
        accept    = issue && mem_addr_ok;
        pop       = !reset && mem_data_ok && (cnt_q != '0);
        head_data = id_q[rd_ptr_q];
    end

    // Forward the owner's request fields; everything reads zero while reset is asserted.
    always_comb begin
        mem_req   = issue;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (!reset) begin
            if (owner_data) begin
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_wstrb = data_sram_wstrb;
                mem_addr  = data_sram_addr;
                mem_wdata = data_sram_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_sram_addr;
            end
        end
    end

    // Steer handshakes and responses to the channel that owns them.
    always_comb begin
        inst_sram_addr_ok = accept && !owner_data;
        data_sram_addr_ok = accept && owner_data;
        inst_sram_data_ok = pop && !head_data;
        data_sram_data_ok = pop && head_data;
        inst_sram_rdata   = reset ? 32'd0 : mem_rdata;
        data_sram_rdata   = reset ? 32'd0 : mem_rdata;
        resp_err          = !reset && resp_err_q;
    end

    // Grant FSM: hold the granted channel until the memory accepts it or the channel withdraws.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (!full) begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && !mem_addr_ok) begin
                        state_q <= owner_data ? ST_HOLD_D : ST_HOLD_I;
                    end
                end
                ST_HOLD_I, ST_HOLD_D: begin
                    if (!owner_req || mem_addr_ok) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // In-order ID FIFO: records which channel each accepted request came from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
        end else begin
            if (accept) begin
                id_q[wr_ptr_q] <= owner_data;
                wr_ptr_q       <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!accept && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_err_q <= 1'b0;
        end else if (mem_data_ok && (cnt_q == '0)) begin
            resp_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Purpose: directed self-checking bench for sram_like_arbiter.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: mem_addr_ok / mem_data_ok are driven directly by the vectors.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_err = 0;

    sram_like_arbiter #(.OUTSTANDING(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata),
        .resp_err          (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        inst_sram_req   = 1'b0;
        inst_sram_addr  = 32'd0;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_wstrb = 4'd0;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        mem_addr_ok     = 1'b0;
        mem_data_ok     = 1'b0;
        mem_rdata       = 32'd0;
    endtask

    initial begin
        // ---- reset: outputs forced low even with live inputs ----
        quiet();
        reset          = 1'b1;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0000;
        mem_addr_ok    = 1'b1;
        mem_data_ok    = 1'b1;
        mem_rdata      = 32'h1234_5678;
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        check("rst_inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check("rst_rdata", inst_sram_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        cyc();
        check("rst_count", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        quiet();
        cyc();

        // ---- inst-only read ----
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0000;
        mem_addr_ok    = 1'b1;
        #1;
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h1c00_0000);
        check("t1_mem_size", 32'(mem_size), 32'd2);
        check("t1_mem_wr", 32'(mem_wr), 32'd0);
        check("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        check("t1_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
        cyc();
        quiet();
        #1;
        check("t1_count1", 32'(dut.cnt_q), 32'd1);
        cyc();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hdead_beef;
        #1;
        check("t1_inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
        check("t1_data_data_ok", 32'(data_sram_data_ok), 32'd0);
        check("t1_inst_rdata", inst_sram_rdata, 32'hdead_beef);
        cyc();
        quiet();
        #1;
        check("t1_inst_data_ok_off", 32'(inst_sram_data_ok), 32'd0);
        check("t1_count0", 32'(dut.cnt_q), 32'd0);

        // ---- both request together: data first, then inst ----
        cyc();
        inst_sram_req   = 1'b1;
        inst_sram_addr  = 32'h1c00_0040;
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'd1;
        data_sram_wstrb = 4'b0011;
        data_sram_addr  = 32'h8000_0010;
        data_sram_wdata = 32'hcafe_f00d;
        mem_addr_ok     = 1'b1;
        #1;
        check("t2_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        check("t2_inst_addr_ok0", 32'(inst_sram_addr_ok), 32'd0);
        check("t2_mem_addr_d", mem_addr, 32'h8000_0010);
        check("t2_mem_wr", 32'(mem_wr), 32'd1);
        check("t2_mem_wdata", mem_wdata, 32'hcafe_f00d);
        check("t2_mem_wstrb", 32'(mem_wstrb), 32'h3);
        check("t2_mem_size", 32'(mem_size), 32'd1);
        cyc();
        data_sram_req = 1'b0;
        #1;
        check("t2_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        check("t2_mem_addr_i", mem_addr, 32'h1c00_0040);
        check("t2_mem_wr_i", 32'(mem_wr), 32'd0);
        cyc();
        quiet();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_00a1;
        #1;
        check("t2_resp1_data", 32'(data_sram_data_ok), 32'd1);
        check("t2_resp1_inst", 32'(inst_sram_data_ok), 32'd0);
        check("t2_resp1_rdata", data_sram_rdata, 32'h0000_00a1);
        cyc();
        mem_rdata = 32'h0000_00b2;
        #1;
        check("t2_resp2_inst", 32'(inst_sram_data_ok), 32'd1);
        check("t2_resp2_data", 32'(data_sram_data_ok), 32'd0);
        check("t2_resp2_rdata", inst_sram_rdata, 32'h0000_00b2);
        cyc();
        quiet();

        // ---- grant held on inst while memory stalls ----
        cyc();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0100;
        #1;
        check("t3_c0_mem_addr", mem_addr, 32'h1c00_0100);
        check("t3_c0_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        cyc();
        #1;
        check("t3_c1_state", 32'(dut.state_q), 32'd1);
        cyc();
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h8000_0200;
        #1;
        check("t3_c2_mem_addr", mem_addr, 32'h1c00_0100);
        check("t3_c2_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
        cyc();
        mem_addr_ok = 1'b1;
        #1;
        check("t3_c3_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        check("t3_c3_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
        cyc();
        inst_sram_req = 1'b0;
        #1;
        check("t3_c4_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        check("t3_c4_mem_addr", mem_addr, 32'h8000_0200);
        cyc();
        quiet();
        mem_data_ok = 1'b1;
        #1;
        check("t3_resp1_inst", 32'(inst_sram_data_ok), 32'd1);
        cyc();
        #1;
        check("t3_resp2_data", 32'(data_sram_data_ok), 32'd1);
        cyc();
        quiet();

        // ---- fill to OUTSTANDING, stall, resume after one response ----
        for (int i = 0; i < 4; i++) begin
            cyc();
            data_sram_req  = 1'b1;
            data_sram_addr = 32'h9000_0000 + 32'(i * 4);
            mem_addr_ok    = 1'b1;
            #1;
            check($sformatf("t4_accept%0d", i), 32'(data_sram_addr_ok), 32'd1);
        end
        cyc();
        #1;
        check("t4_full_mem_req", 32'(mem_req), 32'd0);
        check("t4_full_addr_ok", 32'(data_sram_addr_ok), 32'd0);
        check("t4_full_count", 32'(dut.cnt_q), 32'd4);
        cyc();
        mem_data_ok = 1'b1;
        #1;
        check("t4_popfull_mem_req", 32'(mem_req), 32'd0);
        check("t4_popfull_data_ok", 32'(data_sram_data_ok), 32'd1);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        check("t4_resume_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        check("t4_resume_count", 32'(dut.cnt_q), 32'd3);
        cyc();
        quiet();
        mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_drain%0d", i), 32'(data_sram_data_ok), 32'd1);
            cyc();
        end
        quiet();
        #1;
        check("t4_empty", 32'(dut.cnt_q), 32'd0);

        // ---- stray response ----
        cyc();
        mem_data_ok = 1'b1;
        #1;
        check("t5_no_inst_ok", 32'(inst_sram_data_ok), 32'd0);
        check("t5_no_data_ok", 32'(data_sram_data_ok), 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        check("t5_resp_err", 32'(resp_err), 32'd1);
        check("t5_count", 32'(dut.cnt_q), 32'd0);
        cyc();
        cyc();
        check("t5_resp_err_sticky", 32'(resp_err), 32'd1);

        // ---- reset with two outstanding ----
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0200;
        mem_addr_ok    = 1'b1;
        cyc();
        cyc();
        #1;
        check("t6_pre_count", 32'(dut.cnt_q), 32'd2);
        reset       = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        check("t6_rst_count", 32'(dut.cnt_q), 32'd0);
        check("t6_rst_state", 32'(dut.state_q), 32'd0);
        check("t6_rst_mem_req", 32'(mem_req), 32'd0);
        check("t6_rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        check("t6_rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check("t6_rst_resp_err", 32'(resp_err), 32'd0);
        cyc();
        reset       = 1'b0;
        mem_data_ok = 1'b0;
        #1;
        check("t6_post_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        check("t6_post_mem_addr", mem_addr, 32'h1c00_0200);
        cyc();
        quiet();
        #1;
        check("t6_post_count", 32'(dut.cnt_q), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
